microcpu_sequencer: RTL and testbench

Multi-cycle fetch/decode/execute/writeback sequencer for the 16-bit microcpu core. Owns the program counter and instruction register, fetches instructions over a req/valid instruction-memory handshake, feeds the instruction register to the combinational decoder, and gates the register-file write strobe and PC update so that each instruction retires exactly once. MUL is held in an execute-wait state for a parameterised number of cycles; all other opcodes retire without one.

---
 rtl/microcpu_pkg.sv | 21 ++
 rtl/microcpu_sequencer.sv | 70 +++++++
 tb/tb_microcpu_sequencer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/microcpu_pkg.sv
// microcpu_pkg: opcode constants, sequencer state encoding and PC width
// shared by the microcpu decoder and sequencer.
package microcpu_pkg;
    localparam int PC_WIDTH = 12;
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_MUL = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_LUI = 4'h7;
    localparam logic [3:0] OP_LLI = 4'h8;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB
    } seq_state_t;
endpackage

// File: rtl/microcpu_sequencer.sv
// microcpu_sequencer: fetch/decode/execute/writeback FSM owning pc, instr and
// the retire counter; MUL waits MUL_LATENCY cycles in EXEC before retiring.
module microcpu_sequencer #(
    parameter int PC_WIDTH    = 12,
    parameter int MUL_LATENCY = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [15:0]         imem_rdata,
    input  logic                imem_valid,
    output logic [15:0]         instr,
    input  logic [3:0]          dec_alu_op,
    input  logic                dec_reg_write,
    input  logic                dec_load_pc,
    input  logic [PC_WIDTH-1:0] dec_load_pc_val,
    output logic                rf_we,
    output logic [PC_WIDTH-1:0] pc,
    output logic                busy,
    output logic                retired,
    output logic [31:0]         retire_count
);
    import microcpu_pkg::*;

    seq_state_t state, state_next;
    logic [3:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            pc           <= '0;
            instr        <= '0;
            wait_cnt     <= '0;
            retire_count <= '0;
        end else begin
            state <= state_next;
            if (state == ST_FETCH && imem_valid)
                instr <= imem_rdata;
            if (state == ST_DECODE && dec_alu_op == OP_MUL)
                wait_cnt <= 4'(MUL_LATENCY - 1);
            else if (state == ST_EXEC && wait_cnt != 4'd0)
                wait_cnt <= wait_cnt - 4'd1;
            // Retirement is the only place pc and the counter move.
            if (state == ST_WB) begin
                pc           <= dec_load_pc ? dec_load_pc_val : pc + 1'b1;
                retire_count <= retire_count + 32'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:   state_next = run ? ST_FETCH : ST_IDLE;
            ST_FETCH:  state_next = imem_valid ? ST_DECODE : ST_FETCH;
            ST_DECODE: state_next = (dec_alu_op == OP_MUL) ? ST_EXEC : ST_WB;
            ST_EXEC:   state_next = (wait_cnt == 4'd0) ? ST_WB : ST_EXEC;
            ST_WB:     state_next = run ? ST_FETCH : ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    assign imem_req  = state == ST_FETCH;
    assign imem_addr = pc;
    assign retired   = state == ST_WB;
    assign rf_we     = retired && dec_reg_write;
    assign busy      = state != ST_IDLE;
endmodule

// File: tb/tb_microcpu_sequencer.sv
// tb_microcpu_sequencer: random programs against an instruction-level model;
// each fetch pushes its expected retirement, a monitor checks it in WB.
module tb_microcpu_sequencer;
    localparam int L = 3;

    logic        clk = 0;
    logic        rst;
    logic        run;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic [15:0] instr;
    logic [3:0]  dec_alu_op;
    logic        dec_reg_write;
    logic        dec_load_pc;
    logic [11:0] dec_load_pc_val;
    logic        rf_we;
    logic [11:0] pc;
    logic        busy;
    logic        retired;
    logic [31:0] retire_count;

    microcpu_sequencer #(.PC_WIDTH(12), .MUL_LATENCY(L)) dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .instr(instr), .dec_alu_op(dec_alu_op),
        .dec_reg_write(dec_reg_write), .dec_load_pc(dec_load_pc),
        .dec_load_pc_val(dec_load_pc_val), .rf_we(rf_we), .pc(pc),
        .busy(busy), .retired(retired), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    function automatic logic writes(input logic [3:0] op);
        return op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8};
    endfunction

    // Decoder stand-in driven from the instruction register.
    assign dec_alu_op      = instr[15:12];
    assign dec_reg_write   = writes(instr[15:12]);
    assign dec_load_pc     = instr[15:12] == 4'd6;
    assign dec_load_pc_val = instr[11:0];

    typedef struct {
        logic [15:0] ins;
        logic        we;
        logic [11:0] pc_before;
        logic [11:0] pc_after;
        int          cnt;
        int          hs;
        int          lat;
    } exp_t;

    exp_t        q[$];
    logic [15:0] mem[4096];
    logic [11:0] model_pc = 0;
    int          model_count = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          fetch_n = 0;
    int          wait_left = 0;
    int          cur_wait = 0;
    int          req_cycles = 0;
    bit          stray_en = 1;
    int          dwait[6] = '{0, 0, 4, 0, 0, 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pc"}, 32'(pc), 0);
        chk({tag, "_instr"}, 32'(instr), 0);
        chk({tag, "_count"}, retire_count, 0);
        chk({tag, "_req"}, 32'(imem_req), 0);
        chk({tag, "_rf_we"}, 32'(rf_we), 0);
        chk({tag, "_retired"}, 32'(retired), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    endtask

    task automatic fill_mul();
        for (int i = 0; i < 4096; i++) mem[i] = {4'd3, 12'($urandom)};
    endtask

    task automatic wait_mul_handshake(output bit ok);
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(posedge clk);
            ok = imem_req && imem_valid && imem_rdata[15:12] == 4'd3;
        end
        if (!ok) chk("mul_handshake_timeout", 1, 0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Instruction memory responder and scoreboard producer.
    initial begin
        exp_t e;
        logic [15:0] w;
        imem_valid = 0;
        imem_rdata = 0;
        forever begin
            @(negedge clk);
            if (imem_req && !rst) begin
                req_cycles++;
                chk("fetch_addr", 32'(imem_addr), 32'(model_pc));
                if (wait_left == 0) begin
                    w = mem[model_pc];
                    imem_valid = 1;
                    imem_rdata = w;
                    chk("req_cycles", req_cycles, cur_wait + 1);
                    model_count++;
                    e.ins = w;
                    e.we = writes(w[15:12]);
                    e.pc_before = model_pc;
                    e.pc_after = (w[15:12] == 4'd6) ? w[11:0] : 12'(model_pc + 12'd1);
                    e.cnt = model_count;
                    e.hs = cyc;
                    e.lat = (w[15:12] == 4'd3) ? 2 + L : 2;
                    q.push_back(e);
                    model_pc = e.pc_after;
                    fetch_n++;
                    cur_wait = (fetch_n < 6) ? dwait[fetch_n] : int'($urandom_range(0, 3));
                    wait_left = cur_wait;
                    req_cycles = 0;
                end else begin
                    wait_left--;
                    imem_valid = 0;
                    imem_rdata = 16'($urandom);
                end
            end else begin
                imem_valid = stray_en && ($urandom_range(0, 1) == 1);
                imem_rdata = 16'($urandom);
            end
        end
    end

    // Retirement monitor.
    initial begin
        exp_t e;
        bit post = 0;
        logic [11:0] post_pc;
        int post_cnt;
        forever begin
            @(negedge clk);
            if (post) begin
                chk("pc_after", 32'(pc), 32'(post_pc));
                chk("count_after", retire_count, post_cnt);
                post = 0;
            end
            if (rf_we && !retired) chk("rf_we_outside_wb", 32'(rf_we), 0);
            if (retired) begin
                if (q.size() == 0) chk("unexpected_retire", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("rf_we", 32'(rf_we), 32'(e.we));
                    chk("instr", 32'(instr), 32'(e.ins));
                    chk("latency", cyc - e.hs, e.lat);
                    chk("pc_before", 32'(pc), 32'(e.pc_before));
                    chk("busy_wb", 32'(busy), 1);
                    post = 1;
                    post_pc = e.pc_after;
                    post_cnt = e.cnt;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst = 1;
        run = 0;
        fill_random();
        mem[12'h000] = 16'h1123;
        mem[12'h001] = 16'h3456;
        mem[12'h002] = 16'h6005;
        mem[12'h005] = 16'h6ABC;
        mem[12'hABC] = 16'h6FFF;
        mem[12'hFFF] = 16'h0000;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 0;
        run = 1;

        // Directed chain: ADD, MUL, JMP (delayed fetch), JMP, JMP, NOP at 0xFFF.
        for (int i = 0; i < 200 && model_count < 6; i++) @(posedge clk);
        chk("directed_progress", 32'(model_count >= 6), 1);
        fill_random();
        repeat (1500) @(posedge clk);

        // Drop run during EXEC of a MUL: it retires, then the core parks.
        fill_mul();
        wait_mul_handshake(ok);
        @(negedge clk);
        @(negedge clk);
        run = 0;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = !busy;
        end
        chk("park_idle", 32'(ok), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_no_req", 32'(imem_req), 0);
            chk("idle_not_busy", 32'(busy), 0);
        end
        chk("park_queue_empty", q.size(), 0);
        chk("park_count", retire_count, model_count);

        // Reset during the second EXEC cycle of a MUL.
        run = 1;
        wait_mul_handshake(ok);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("exec2_busy", 32'(busy), 1);
        chk("exec2_no_retire", 32'(retired), 0);
        rst = 1;
        @(negedge clk);
        check_reset_outputs("midexec_reset");
        q.delete();
        model_pc = 0;
        model_count = 0;
        wait_left = 0;
        cur_wait = 0;
        req_cycles = 0;
        rst = 0;
        fill_random();
        repeat (1500) @(posedge clk);

        @(negedge clk);
        run = 0;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = !busy;
        end
        chk("final_idle", 32'(ok), 1);
        @(negedge clk);
        chk("final_queue_empty", q.size(), 0);
        chk("final_count", retire_count, model_count);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
